// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters,
// mispredict detection and branch statistics.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   if_pc               fetch PC to look up
//   pred_taken          lookup says taken (combinational)
//   pred_target         predicted next PC (if_pc+4 if not taken)
//   upd_valid           EX resolves a conditional branch
//   upd_pc              PC of the resolved branch
//   upd_taken           comparator result
//   upd_target          computed branch target
//   ex_pred_taken       IF prediction piped to EX
//   ex_pred_target      IF predicted target piped to EX
//   mispredict          IF prediction was wrong
//   redirect_pc         correct next PC for the branch
//   br_count, mp_count  saturating branch / mispredict counts
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [31:0]        tgt_mem [ENTRIES];
  logic [1:0]         cnt_mem [ENTRIES];

  logic [INDEX_BITS-1:0] l_idx;
  logic [TAG_W-1:0]      l_tag;
  logic                  l_hit;

  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_W-1:0]      u_tag;
  logic                  u_hit;
  logic [1:0]            u_cnt;
  logic [1:0]            cnt_nxt;

  assign l_idx = if_pc[INDEX_BITS+1:2];
  assign l_tag = if_pc[31:INDEX_BITS+2];
  assign l_hit = valid[l_idx]
              && (tag_mem[l_idx] == l_tag);

  assign pred_taken  = l_hit && cnt_mem[l_idx][1];
  assign pred_target = pred_taken ? tgt_mem[l_idx]
                                  : if_pc + 32'd4;

  assign u_idx = upd_pc[INDEX_BITS+1:2];
  assign u_tag = upd_pc[31:INDEX_BITS+2];
  assign u_hit = valid[u_idx]
              && (tag_mem[u_idx] == u_tag);
  assign u_cnt = cnt_mem[u_idx];

  always_comb begin
    cnt_nxt = u_cnt;
    unique case (1'b1)
      !u_hit && upd_taken:
        cnt_nxt = 2'b10;
      !u_hit && !upd_taken:
        cnt_nxt = 2'b01;
      u_hit && upd_taken:
        cnt_nxt = (u_cnt == 2'b11) ? u_cnt
                                   : u_cnt + 2'd1;
      default:
        cnt_nxt = (u_cnt == 2'b00) ? u_cnt
                                   : u_cnt - 2'd1;
    endcase
  end

  assign mispredict = upd_valid
    && ((ex_pred_taken != upd_taken)
     || (upd_taken
      && (ex_pred_target != upd_target)));

  assign redirect_pc = upd_taken ? upd_target
                                 : upd_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++)
        cnt_mem[i] <= CNT_INIT;
    end else if (upd_valid) begin
      valid[u_idx]   <= 1'b1;
      cnt_mem[u_idx] <= cnt_nxt;
    end
  end

  // Tag/target need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      tag_mem[u_idx] <= u_tag;
      if (!u_hit || upd_taken)
        tgt_mem[u_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (upd_valid && (br_count != '1))
        br_count <= br_count + 32'd1;
      if (mispredict && (mp_count != '1))
        mp_count <= mp_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: vector table plus scoreboard
// checks for branch_predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
    logic        ept;
    logic [31:0] eptg;
    logic [31:0] ifpc;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mp;
    logic [31:0] e_rd;
  } vec_t;

  typedef struct {
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rd;
  } exp_t;

  vec_t vecs[16];
  exp_t sbq[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic idle();
    upd_valid      = 1'b0;
    upd_pc         = 32'h0;
    upd_taken      = 1'b0;
    upd_target     = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
  endtask

  // Drive at negedge, queue expectation, sample 2ns later.
  task automatic apply(input vec_t x, input int n);
    exp_t e;
    exp_t g;
    @(negedge clk);
    upd_valid      = x.v;
    upd_pc         = x.pc;
    upd_taken      = x.tk;
    upd_target     = x.tgt;
    ex_pred_taken  = x.ept;
    ex_pred_target = x.eptg;
    if_pc          = x.ifpc;
    e.pt  = x.e_pt;
    e.ptg = x.e_ptg;
    e.mp  = x.e_mp;
    e.rd  = x.e_rd;
    sbq.push_back(e);
    #2;
    g = sbq.pop_front();
    chk($sformatf("v%0d pred_taken", n),
        {31'b0, pred_taken}, {31'b0, g.pt});
    chk($sformatf("v%0d pred_target", n),
        pred_target, g.ptg);
    chk($sformatf("v%0d mispredict", n),
        {31'b0, mispredict}, {31'b0, g.mp});
    chk($sformatf("v%0d redirect_pc", n),
        redirect_pc, g.rd);
  endtask

  initial begin
    // v  pc  tk tgt  ept eptg  ifpc | pt ptg mp rd
    vecs[0]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0,
                 32'h100, 0, 32'h104, 0, 32'h4};
    vecs[1]  = '{1, 32'h100, 1, 32'h80, 0, 32'h0,
                 32'h100, 0, 32'h104, 1, 32'h80};
    vecs[2]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0,
                 32'h100, 1, 32'h80, 0, 32'h4};
    vecs[3]  = '{1, 32'h100, 1, 32'h80, 1, 32'h80,
                 32'h100, 1, 32'h80, 0, 32'h80};
    vecs[4]  = '{1, 32'h100, 1, 32'h80, 1, 32'h80,
                 32'h100, 1, 32'h80, 0, 32'h80};
    vecs[5]  = '{1, 32'h100, 0, 32'h80, 1, 32'h80,
                 32'h100, 1, 32'h80, 1, 32'h104};
    vecs[6]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0,
                 32'h100, 1, 32'h80, 0, 32'h4};
    vecs[7]  = '{1, 32'h100, 0, 32'h80, 1, 32'h80,
                 32'h100, 1, 32'h80, 1, 32'h104};
    vecs[8]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0,
                 32'h100, 0, 32'h104, 0, 32'h4};
    vecs[9]  = '{1, 32'h100, 1, 32'h80, 0, 32'h0,
                 32'h100, 0, 32'h104, 1, 32'h80};
    vecs[10] = '{1, 32'h100, 1, 32'h80, 1, 32'h80,
                 32'h100, 1, 32'h80, 0, 32'h80};
    vecs[11] = '{1, 32'h100, 1, 32'h200, 1, 32'h80,
                 32'h100, 1, 32'h80, 1, 32'h200};
    vecs[12] = '{0, 32'h0, 0, 32'h0, 0, 32'h0,
                 32'h100, 1, 32'h200, 0, 32'h4};
    vecs[13] = '{1, 32'h1100, 0, 32'h300, 0, 32'h0,
                 32'h1100, 0, 32'h1104, 0, 32'h1104};
    vecs[14] = '{0, 32'h0, 0, 32'h0, 0, 32'h0,
                 32'h100, 0, 32'h104, 0, 32'h4};
    vecs[15] = '{0, 32'hFFFFFFFC, 0, 32'h0,
                 1, 32'h40, 32'hFFFFFFFC,
                 0, 32'h0, 0, 32'h0};

    idle();
    if_pc = 32'h100;
    rst_n = 1'b0;
    #1;
    chk("rst pred_taken",
        {31'b0, pred_taken}, 32'h0);
    chk("rst pred_target", pred_target, 32'h104);
    chk("rst mispredict",
        {31'b0, mispredict}, 32'h0);
    chk("rst br_count", br_count, 32'h0);
    chk("rst mp_count", mp_count, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      apply(vecs[i], i);

    @(negedge clk);
    idle();
    #1;
    chk("br_count", br_count, 32'd9);
    chk("mp_count", mp_count, 32'd5);
    chk("sb empty", sbq.size(), 32'd0);

    // Retrain 0x100, then reset between edges.
    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_taken  = 1'b1;
    upd_target = 32'h80;
    if_pc      = 32'h100;
    @(negedge clk);
    idle();
    #1;
    chk("pre-rst pred_taken",
        {31'b0, pred_taken}, 32'h1);
    chk("pre-rst br_count", br_count, 32'd10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid-rst pred_taken",
        {31'b0, pred_taken}, 32'h0);
    chk("mid-rst pred_target",
        pred_target, 32'h104);
    chk("mid-rst br_count", br_count, 32'h0);
    chk("mid-rst mp_count", mp_count, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post-rst pred_taken",
        {31'b0, pred_taken}, 32'h0);
    chk("post-rst pred_target",
        pred_target, 32'h104);
    chk("post-rst br_count", br_count, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
